ea_sample_capture: RTL and testbench

Synthesizable capture stage upstream of the Error Analyzer DPI layer. It timestamps each (read, expected) data pair presented by a DUT-side monitor and buffers it in a FIFO. It presents the pairs on a ready/valid port to the testbench drain, which calls the Analyzer add-sample function once per popped entry. It also keeps mismatch/drop statistics and signals end-of-drain so the bench knows when to run the Analyzer checks.

---
 rtl/ea_capture_pkg.sv | 28 ++
 rtl/ea_sample_fifo.sv | 57 +++++
 rtl/ea_sample_capture.sv | 154 +++++++++++++++
 tb/tb_ea_sample_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ea_capture_pkg.sv
// rtl/ea_capture_pkg.sv - shared types and constants for the Error Analyzer sample capture stage
package ea_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } cap_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int TS_W_DEF   = 64;

    // One buffered entry at the default widths; the FIFO stores the same
    // fields packed in this order for any parameterization.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] read;
        logic [DATA_W_DEF-1:0] exp;
        logic [TS_W_DEF-1:0]   ts;
        logic                  mismatch;
    } sample_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ea_sample_fifo.sv
// rtl/ea_sample_fifo.sv - first-word-fall-through FIFO with clear and occupancy level
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write strobe and entry (caller guarantees room or a same-cycle pop)
//   pop               advance head (caller guarantees non-empty)
//   clear             synchronous flush, wins over push/pop
//   head_data         current head entry (undefined while empty)
//   full, empty       occupancy flags
//   level             number of stored entries
module ea_sample_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [W-1:0]           head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Push while full is only legal with a pop, which frees the head slot
    // that wptr aliases at the same edge.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rptr[AW-1:0]];
    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level     = wptr - rptr;

endmodule

// File: rtl/ea_sample_capture.sv
// rtl/ea_sample_capture.sv - timestamps and buffers (read, expected) pairs for the Error Analyzer drain
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   en_i, clear_i                 capture enable level, synchronous flush of FIFO and statistics
//   smp_valid_i/smp_ready_o       sample handshake (ready only in CAPTURE)
//   smp_read_i, smp_exp_i         sample read and expected data
//   out_valid_o/out_ready_i       drain handshake, FWFT head entry
//   out_read_o, out_exp_o,
//   out_time_o, out_mismatch_o    head entry fields, zero while empty
//   level_o                       FIFO occupancy
//   mismatch_cnt_o, drop_cnt_o    saturating statistics
//   overflow_o                    sticky drop flag
//   done_o                        pulse when DRAIN empties and returns to IDLE
module ea_sample_capture
    import ea_capture_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic                   smp_valid_i,
    output logic                   smp_ready_o,
    input  logic [DATA_W-1:0]      smp_read_i,
    input  logic [DATA_W-1:0]      smp_exp_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_W-1:0]      out_read_o,
    output logic [DATA_W-1:0]      out_exp_o,
    output logic [TS_W-1:0]        out_time_o,
    output logic                   out_mismatch_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [15:0]            mismatch_cnt_o,
    output logic [15:0]            drop_cnt_o,
    output logic                   overflow_o,
    output logic                   done_o
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int SMP_W = 2*DATA_W + TS_W + 1;

    cap_state_t        state;
    logic              ready_q;
    logic              done_q;
    logic [TS_W-1:0]   ts_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  level;
    logic [SMP_W-1:0]  push_data;
    logic [SMP_W-1:0]  head_data;
    logic              smp_mismatch;
    logic              push_req;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic              drain_empty_next;

    assign smp_mismatch = (smp_read_i != smp_exp_i);
    assign push_req     = smp_valid_i & ready_q;
    assign pop          = ~fifo_empty & out_ready_i;
    assign push_ok      = push_req & (~fifo_full | pop);
    assign drop         = push_req & fifo_full & ~pop;
    assign push_data    = {smp_read_i, smp_exp_i, ts_cnt, smp_mismatch};

    // No pushes happen in DRAIN, so the FIFO is empty next cycle if it is
    // empty now, its last entry pops now, or a clear flushes it.
    assign drain_empty_next = clear_i | fifo_empty | ((level == LVL_W'(1)) & pop);

    ea_sample_fifo #(
        .W     (SMP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (pop),
        .clear     (clear_i),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + TS_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i) begin
                        state   <= CAPTURE;
                        ready_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!en_i) begin
                        state   <= DRAIN;
                        ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (en_i) begin
                        state   <= CAPTURE;
                        ready_q <= 1'b1;
                    end else if (drain_empty_next) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_cnt_o <= '0;
            drop_cnt_o     <= '0;
            overflow_o     <= 1'b0;
        end else if (clear_i) begin
            mismatch_cnt_o <= '0;
            drop_cnt_o     <= '0;
            overflow_o     <= 1'b0;
        end else begin
            if (push_ok && smp_mismatch) mismatch_cnt_o <= sat_inc(mismatch_cnt_o);
            if (drop) begin
                drop_cnt_o <= sat_inc(drop_cnt_o);
                overflow_o <= 1'b1;
            end
        end
    end

    assign smp_ready_o = ready_q;
    assign done_o      = done_q;
    assign out_valid_o = ~fifo_empty;
    assign level_o     = level;
    assign {out_read_o, out_exp_o, out_time_o, out_mismatch_o} = fifo_empty ? '0 : head_data;

endmodule

// File: tb/tb_ea_sample_capture.sv
// tb/tb_ea_sample_capture.sv - directed self-checking bench for ea_sample_capture
module tb_ea_sample_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        sv = 1'b0;
    logic        ordy = 1'b0;
    logic [15:0] sr = '0;
    logic [15:0] se = '0;
    logic        srdy;
    logic        ov;
    logic [15:0] ord;
    logic [15:0] oex;
    logic [7:0]  otm;
    logic        omm;
    logic [4:0]  lvl;
    logic [15:0] mcnt;
    logic [15:0] dcnt;
    logic        ovf;
    logic        done;

    logic [7:0]  tb_ts;
    int          errors = 0;
    int          checks = 0;

    ea_sample_capture #(.DATA_W(16), .DEPTH(16), .TS_W(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .clear_i        (clr),
        .smp_valid_i    (sv),
        .smp_ready_o    (srdy),
        .smp_read_i     (sr),
        .smp_exp_i      (se),
        .out_valid_o    (ov),
        .out_ready_i    (ordy),
        .out_read_o     (ord),
        .out_exp_o      (oex),
        .out_time_o     (otm),
        .out_mismatch_o (omm),
        .level_o        (lvl),
        .mismatch_cnt_o (mcnt),
        .drop_cnt_o     (dcnt),
        .overflow_o     (ovf),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    // Reference timestamp: zero in reset, +1 per clock, wraps at 256.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= 8'd0;
        else     tb_ts <= tb_ts + 8'd1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ov !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %0h expected 0", ov); end
        checks++; if (lvl !== 5'd0)   begin errors++; $display("FAIL rst_level: got %0d expected 0", lvl); end
        checks++; if (mcnt !== 16'd0) begin errors++; $display("FAIL rst_mcnt: got %0d expected 0", mcnt); end
        checks++; if (dcnt !== 16'd0) begin errors++; $display("FAIL rst_dcnt: got %0d expected 0", dcnt); end
        checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL rst_ovf: got %0h expected 0", ovf); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rst_done: got %0h expected 0", done); end
        checks++; if (srdy !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %0h expected 0", srdy); end
        checks++; if (otm !== 8'd0)   begin errors++; $display("FAIL rst_time: got %0d expected 0", otm); end
        rst = 1'b0;
    endtask

    task automatic test_first_sample;
        en = 1'b1;
        tick();
        for (int i = 0; i < 300 && tb_ts != 8'd10; i++) tick();
        checks++; if (tb_ts !== 8'd10) begin errors++; $display("FAIL first_wait_ts: got %0d expected 10", tb_ts); end
        checks++; if (srdy !== 1'b1)   begin errors++; $display("FAIL first_ready: got %0h expected 1", srdy); end
        sv = 1'b1; sr = 16'h0012; se = 16'h0012;
        tick();
        sv = 1'b0;
        checks++; if (ov !== 1'b1)      begin errors++; $display("FAIL first_valid: got %0h expected 1", ov); end
        checks++; if (otm !== 8'd10)    begin errors++; $display("FAIL first_time: got %0d expected 10", otm); end
        checks++; if (omm !== 1'b0)     begin errors++; $display("FAIL first_mismatch: got %0h expected 0", omm); end
        checks++; if (lvl !== 5'd1)     begin errors++; $display("FAIL first_level: got %0d expected 1", lvl); end
        checks++; if (ord !== 16'h0012) begin errors++; $display("FAIL first_read: got %0h expected 12", ord); end
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        checks++; if (lvl !== 5'd0)  begin errors++; $display("FAIL first_pop_level: got %0d expected 0", lvl); end
        checks++; if (ord !== 16'd0) begin errors++; $display("FAIL first_empty_data: got %0h expected 0", ord); end
    endtask

    task automatic test_mismatch_order;
        logic [15:0] rd [3];
        logic [15:0] ex [3];
        logic        mm [3];
        logic [7:0]  tm [3];
        rd = '{16'h0011, 16'h00A5, 16'h0033};
        ex = '{16'h0011, 16'h00A4, 16'h0033};
        mm = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            sv = 1'b1; sr = rd[i]; se = ex[i]; tm[i] = tb_ts;
            tick();
        end
        sv = 1'b0;
        checks++; if (mcnt !== 16'd1) begin errors++; $display("FAIL mm_count: got %0d expected 1", mcnt); end
        checks++; if (lvl !== 5'd3)   begin errors++; $display("FAIL mm_level: got %0d expected 3", lvl); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ord !== rd[i]) begin errors++; $display("FAIL mm_read[%0d]: got %0h expected %0h", i, ord, rd[i]); end
            checks++; if (oex !== ex[i]) begin errors++; $display("FAIL mm_exp[%0d]: got %0h expected %0h", i, oex, ex[i]); end
            checks++; if (omm !== mm[i]) begin errors++; $display("FAIL mm_flag[%0d]: got %0h expected %0h", i, omm, mm[i]); end
            checks++; if (otm !== tm[i]) begin errors++; $display("FAIL mm_time[%0d]: got %0d expected %0d", i, otm, tm[i]); end
            ordy = 1'b1;
            tick();
            ordy = 1'b0;
        end
        checks++; if (lvl !== 5'd0) begin errors++; $display("FAIL mm_drained: got %0d expected 0", lvl); end
    endtask

    task automatic test_overflow;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (mcnt !== 16'd0) begin errors++; $display("FAIL ovfl_clear_mcnt: got %0d expected 0", mcnt); end
        for (int i = 0; i < 20; i++) begin
            sv = 1'b1; sr = 16'(i); se = 16'(i);
            tick();
        end
        sv = 1'b0;
        checks++; if (lvl !== 5'd16)  begin errors++; $display("FAIL ovfl_level: got %0d expected 16", lvl); end
        checks++; if (dcnt !== 16'd4) begin errors++; $display("FAIL ovfl_drops: got %0d expected 4", dcnt); end
        checks++; if (ovf !== 1'b1)   begin errors++; $display("FAIL ovfl_flag: got %0h expected 1", ovf); end
        checks++; if (ord !== 16'd0)  begin errors++; $display("FAIL ovfl_head: got %0h expected 0", ord); end
        sv = 1'b1; sr = 16'h0BEE; se = 16'h0BEE; ordy = 1'b1;
        tick();
        sv = 1'b0; ordy = 1'b0;
        checks++; if (dcnt !== 16'd4) begin errors++; $display("FAIL ovfl_pushpop_drops: got %0d expected 4", dcnt); end
        checks++; if (lvl !== 5'd16)  begin errors++; $display("FAIL ovfl_pushpop_level: got %0d expected 16", lvl); end
        checks++; if (ord !== 16'd1)  begin errors++; $display("FAIL ovfl_pushpop_head: got %0h expected 1", ord); end
    endtask

    task automatic test_clear_push;
        sv = 1'b1; sr = 16'h0077; se = 16'h0078; clr = 1'b1;
        tick();
        sv = 1'b0; clr = 1'b0;
        checks++; if (lvl !== 5'd0)   begin errors++; $display("FAIL clr_level: got %0d expected 0", lvl); end
        checks++; if (ov !== 1'b0)    begin errors++; $display("FAIL clr_valid: got %0h expected 0", ov); end
        checks++; if (mcnt !== 16'd0) begin errors++; $display("FAIL clr_mcnt: got %0d expected 0", mcnt); end
        checks++; if (dcnt !== 16'd0) begin errors++; $display("FAIL clr_dcnt: got %0d expected 0", dcnt); end
        checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL clr_ovf: got %0h expected 0", ovf); end
        checks++; if (srdy !== 1'b1)  begin errors++; $display("FAIL clr_state_kept: got %0h expected 1", srdy); end
    endtask

    task automatic test_drain_done;
        int   done_cnt;
        logic seen_empty;
        logic done_at_empty;
        for (int i = 0; i < 5; i++) begin
            sv = 1'b1; sr = 16'h0100 + 16'(i); se = 16'h0100 + 16'(i);
            tick();
        end
        sv = 1'b0; en = 1'b0;
        tick();
        checks++; if (srdy !== 1'b0) begin errors++; $display("FAIL drain_ready: got %0h expected 0", srdy); end
        checks++; if (lvl !== 5'd5)  begin errors++; $display("FAIL drain_level: got %0d expected 5", lvl); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL drain_early_done: got %0h expected 0", done); end
        done_cnt = 0; seen_empty = 1'b0; done_at_empty = 1'b0;
        ordy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            if (lvl == 5'd0 && !seen_empty) begin
                seen_empty = 1'b1;
                done_at_empty = done;
            end
        end
        ordy = 1'b0;
        checks++; if (done_cnt != 1)         begin errors++; $display("FAIL drain_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_at_empty !== 1'b1) begin errors++; $display("FAIL drain_done_timing: got %0h expected 1", done_at_empty); end
        checks++; if (lvl !== 5'd0)          begin errors++; $display("FAIL drain_final_level: got %0d expected 0", lvl); end
    endtask

    task automatic test_wrap;
        logic [7:0] tm [3];
        tm = '{8'd254, 8'd255, 8'd0};
        en = 1'b1;
        tick();
        for (int i = 0; i < 300 && tb_ts != 8'd254; i++) tick();
        checks++; if (tb_ts !== 8'd254) begin errors++; $display("FAIL wrap_wait_ts: got %0d expected 254", tb_ts); end
        for (int i = 0; i < 3; i++) begin
            sv = 1'b1; sr = 16'h00C0 + 16'(i); se = 16'h00C0 + 16'(i);
            tick();
        end
        sv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (otm !== tm[i]) begin errors++; $display("FAIL wrap_time[%0d]: got %0d expected %0d", i, otm, tm[i]); end
            checks++; if (ord !== 16'h00C0 + 16'(i)) begin errors++; $display("FAIL wrap_read[%0d]: got %0h expected %0h", i, ord, 16'h00C0 + 16'(i)); end
            ordy = 1'b1;
            tick();
            ordy = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            sv = 1'b1; sr = 16'h0200 + 16'(i); se = (i == 1) ? 16'h0000 : 16'h0200 + 16'(i);
            tick();
        end
        sv = 1'b0; en = 1'b0;
        tick();
        checks++; if (lvl !== 5'd3)   begin errors++; $display("FAIL rmid_level_pre: got %0d expected 3", lvl); end
        checks++; if (mcnt !== 16'd1) begin errors++; $display("FAIL rmid_mcnt_pre: got %0d expected 1", mcnt); end
        ordy = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ov !== 1'b0)    begin errors++; $display("FAIL rmid_valid: got %0h expected 0", ov); end
        checks++; if (lvl !== 5'd0)   begin errors++; $display("FAIL rmid_level: got %0d expected 0", lvl); end
        checks++; if (ord !== 16'd0)  begin errors++; $display("FAIL rmid_read: got %0h expected 0", ord); end
        checks++; if (otm !== 8'd0)   begin errors++; $display("FAIL rmid_time: got %0d expected 0", otm); end
        checks++; if (mcnt !== 16'd0) begin errors++; $display("FAIL rmid_mcnt: got %0d expected 0", mcnt); end
        checks++; if (omm !== 1'b0)   begin errors++; $display("FAIL rmid_mismatch: got %0h expected 0", omm); end
        ordy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_mismatch_order();
        test_overflow();
        test_clear_push();
        test_drain_done();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
